// File: rtl/procb_ring_buf.sv
// procb_ring_buf: per-thread circular record FIFO with a read-ahead lookup pointer (FWFT dout).
// Optional error detail ports (err_thread, err_cnt) are enabled by defining PROCB_RING_BUF_ERR_INFO_EN.
`ifndef PROCB_D_WIDTH
`define PROCB_D_WIDTH 32
`endif

module procb_ring_buf #(
    parameter int N_THREADS     = 16,
    parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1,
    parameter int D_WIDTH       = `PROCB_D_WIDTH,
    parameter int N_RECORDS     = 8,
    parameter int A_WIDTH       = $clog2(N_RECORDS) + 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N_THREADS_MSB:0]   wr_thread_num,
    input  logic                     wr_en,
    input  logic [D_WIDTH-1:0]       din,
    output logic [A_WIDTH-1:0]       wr_cnt,
    output logic                     wr_full,
    output logic                     err,
`ifdef PROCB_RING_BUF_ERR_INFO_EN
    output logic [N_THREADS_MSB:0]   err_thread,
    output logic [7:0]               err_cnt,
`endif
    input  logic [N_THREADS_MSB:0]   rd_thread_num,
    input  logic                     rd_en,
    input  logic                     rd_rst,
    input  logic                     lookup_en,
    output logic                     empty,
    output logic                     aempty,
    output logic                     lookup_empty,
    output logic [D_WIDTH-1:0]       dout
);
    localparam int IW = A_WIDTH - 1;

    typedef logic [A_WIDTH-1:0]     ptr_t;
    typedef logic [N_THREADS_MSB:0] thr_t;
    localparam ptr_t ONE  = ptr_t'(1);
    localparam ptr_t FULL = ptr_t'(N_RECORDS);

    typedef enum logic {ST_SWEEP, ST_RUN} state_e;
    state_e state_q, state_d;
    thr_t   sweep_q, sweep_d;
    logic   run;

    logic [D_WIDTH-1:0] mem        [N_THREADS*N_RECORDS];
    ptr_t               wr_ptr_mem [N_THREADS];
    ptr_t               rd_ptr_mem [N_THREADS];

    ptr_t wr_cnt_q, wr_cnt_d;
    logic err_q, err_d;
    thr_t rd_thread_q;
    ptr_t lookup_q, lookup_d;
    logic empty_q, empty_d;
    logic aempty_q, aempty_d;
    logic lookup_empty_q, lookup_empty_d;

    ptr_t wr_wptr_cur, wr_rptr_cur, wr_occ_cur, wr_wptr_next, wr_rptr_next;
    logic wr_accept, wr_reject;
    ptr_t rd_wptr_cur, rd_rptr_cur, rd_wptr_next, rd_rptr_next;
    logic same_thr, thr_chg, pop;

    // Pointer RAMs have no reset; they are zeroed one thread per cycle after RST.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_SWEEP: begin
                sweep_d = sweep_q + thr_t'(1);
                if (sweep_q == '1) state_d = ST_RUN;
            end
            default: ;
        endcase
    end

    assign run = (state_q == ST_RUN);

    always_comb begin
        wr_wptr_cur  = wr_ptr_mem[wr_thread_num];
        wr_rptr_cur  = rd_ptr_mem[wr_thread_num];
        wr_occ_cur   = wr_wptr_cur - wr_rptr_cur;
        wr_reject    = run && wr_en && (wr_occ_cur == FULL);
        wr_accept    = run && wr_en && (wr_occ_cur != FULL);
        wr_wptr_next = wr_accept ? wr_wptr_cur + ONE : wr_wptr_cur;
    end

    always_comb begin
        rd_wptr_cur  = wr_ptr_mem[rd_thread_num];
        rd_rptr_cur  = rd_ptr_mem[rd_thread_num];
        same_thr     = (wr_thread_num == rd_thread_num);
        thr_chg      = (rd_thread_num != rd_thread_q);
        rd_wptr_next = (same_thr && wr_accept) ? wr_wptr_next : rd_wptr_cur;
        pop          = run && rd_en && !empty_q && !thr_chg;

        rd_rptr_next = rd_rptr_cur;
        if (pop) rd_rptr_next = rd_rst ? rd_wptr_next : rd_rptr_cur + ONE;

        // A pop drags lookup along to the new head unless lookup is advancing itself.
        lookup_d = lookup_q;
        if (!run)                                lookup_d = '0;
        else if (thr_chg)                        lookup_d = rd_rptr_cur;
        else if (pop && (rd_rst || !lookup_en))  lookup_d = rd_rptr_next;
        else if (lookup_en && !lookup_empty_q)   lookup_d = lookup_q + ONE;

        wr_rptr_next   = (same_thr && pop) ? rd_rptr_next : wr_rptr_cur;
        wr_cnt_d       = run ? (wr_wptr_next - wr_rptr_next) : '0;
        empty_d        = !run || (rd_wptr_next == rd_rptr_next);
        aempty_d       = run && ((rd_wptr_next - rd_rptr_next) == ONE);
        lookup_empty_d = !run || (lookup_d == rd_wptr_next);
        err_d          = err_q || wr_reject;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= ST_SWEEP;
            sweep_q        <= '0;
            wr_cnt_q       <= '0;
            err_q          <= 1'b0;
            rd_thread_q    <= '0;
            lookup_q       <= '0;
            empty_q        <= 1'b1;
            aempty_q       <= 1'b0;
            lookup_empty_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            sweep_q        <= sweep_d;
            wr_cnt_q       <= wr_cnt_d;
            err_q          <= err_d;
            rd_thread_q    <= rd_thread_num;
            lookup_q       <= lookup_d;
            empty_q        <= empty_d;
            aempty_q       <= aempty_d;
            lookup_empty_q <= lookup_empty_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_accept) mem[{wr_thread_num, wr_wptr_cur[IW-1:0]}] <= din;
    end

    always_ff @(posedge CLK) begin
        if (!run) begin
            wr_ptr_mem[sweep_q] <= '0;
            rd_ptr_mem[sweep_q] <= '0;
        end else begin
            if (wr_accept) wr_ptr_mem[wr_thread_num] <= wr_wptr_next;
            if (pop)       rd_ptr_mem[rd_thread_num] <= rd_rptr_next;
        end
    end

`ifdef PROCB_RING_BUF_ERR_INFO_EN
    thr_t       err_thread_q;
    logic [7:0] err_cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_thread_q <= '0;
            err_cnt_q    <= '0;
        end else if (wr_reject) begin
            if (!err_q)             err_thread_q <= wr_thread_num;
            if (err_cnt_q != 8'hFF) err_cnt_q    <= err_cnt_q + 8'd1;
        end
    end

    assign err_thread = err_thread_q;
    assign err_cnt    = err_cnt_q;
`endif

    assign wr_cnt       = wr_cnt_q;
    assign wr_full      = (wr_cnt_q == FULL);
    assign err          = err_q;
    assign empty        = empty_q;
    assign aempty       = aempty_q;
    assign lookup_empty = lookup_empty_q;
    assign dout         = mem[{rd_thread_num, lookup_q[IW-1:0]}];

endmodule

// File: tb/tb_procb_ring_buf.sv
// Bench for procb_ring_buf: per-thread queue model checked every cycle, plus directed literal checks.
module tb_procb_ring_buf;
    localparam int NT = 16;
    localparam int DW = 32;
    localparam int NR = 8;
    localparam int AW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [3:0]    wr_thread_num = '0;
    logic [3:0]    rd_thread_num = '0;
    logic          wr_en = 1'b0, rd_en = 1'b0, rd_rst = 1'b0, lookup_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic [AW-1:0] wr_cnt;
    logic          wr_full, err, empty, aempty, lookup_empty;
    logic [DW-1:0] dout;
`ifdef PROCB_RING_BUF_ERR_INFO_EN
    logic [3:0]    err_thread;
    logic [7:0]    err_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    procb_ring_buf #(
        .N_THREADS (NT),
        .D_WIDTH   (DW),
        .N_RECORDS (NR)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .wr_thread_num (wr_thread_num),
        .wr_en         (wr_en),
        .din           (din),
        .wr_cnt        (wr_cnt),
        .wr_full       (wr_full),
        .err           (err),
`ifdef PROCB_RING_BUF_ERR_INFO_EN
        .err_thread    (err_thread),
        .err_cnt       (err_cnt),
`endif
        .rd_thread_num (rd_thread_num),
        .rd_en         (rd_en),
        .rd_rst        (rd_rst),
        .lookup_en     (lookup_en),
        .empty         (empty),
        .aempty        (aempty),
        .lookup_empty  (lookup_empty),
        .dout          (dout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Model: one queue per thread; lk is the lookup offset from the head of the read thread.
    logic [DW-1:0] mq [NT][$];
    int  lk, sweep_left, prev_rd, m_wt, m_rt, m_wsz, m_rsz;
    bit  m_err, m_chg, m_acc, m_pop, m_lk_end;
    int  exp_cnt;
    bit  exp_empty, exp_aempty, exp_lke;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int t = 0; t < NT; t++) mq[t].delete();
            lk = 0; sweep_left = NT; m_err = 0; prev_rd = 0;
            exp_cnt = 0; exp_empty = 1; exp_aempty = 0; exp_lke = 1;
        end else if (sweep_left > 0) begin
            sweep_left--;
            prev_rd = int'(rd_thread_num);
            lk = 0;
        end else begin
            m_wt = int'(wr_thread_num);
            m_rt = int'(rd_thread_num);
            m_wsz = mq[m_wt].size();
            m_rsz = mq[m_rt].size();
            m_chg = (m_rt != prev_rd);
            m_lk_end = (lk == m_rsz);
            m_acc = wr_en && (m_wsz < NR);
            if (wr_en && m_wsz == NR) m_err = 1;
            m_pop = rd_en && !m_chg && (m_rsz > 0);
            if (m_acc) mq[m_wt].push_back(din);
            if (m_chg) lk = 0;
            else if (m_pop && rd_rst) begin
                mq[m_rt].delete();
                lk = 0;
            end else if (m_pop) begin
                void'(mq[m_rt].pop_front());
                if (!lookup_en) lk = 0;
                else if (m_lk_end) lk = lk - 1;
            end else if (lookup_en && !m_lk_end) lk++;
            prev_rd = m_rt;
            exp_cnt = mq[m_wt].size();
            exp_empty = (mq[m_rt].size() == 0);
            exp_aempty = (mq[m_rt].size() == 1);
            exp_lke = (lk == mq[m_rt].size());
        end
    end

    always @(negedge CLK) begin
        chk("cmp_wr_cnt", wr_cnt, exp_cnt);
        chk("cmp_wr_full", wr_full, exp_cnt == NR);
        chk("cmp_err", err, m_err);
        chk("cmp_empty", empty, exp_empty);
        chk("cmp_aempty", aempty, exp_aempty);
        chk("cmp_lookup_empty", lookup_empty, exp_lke);
        if (!RST && !exp_lke && int'(rd_thread_num) == prev_rd)
            chk("cmp_dout", dout, mq[rd_thread_num][lk]);
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (3) step();
        RST = 1'b0;
        // Writes during the pointer sweep must be ignored.
        wr_en = 1'b1; din = 32'hDEAD;
        repeat (3) step();
        wr_en = 1'b0;
        repeat (NT - 2) step();
        chk("lit_reset_wr_cnt", wr_cnt, 0);
        chk("lit_reset_empty", empty, 1);
        chk("lit_reset_lookup_empty", lookup_empty, 1);
        chk("lit_reset_err", err, 0);
        chk("lit_reset_aempty", aempty, 0);

        // Flush and simultaneous read/write on thread 1.
        wr_thread_num = 4'd1; rd_thread_num = 4'd1; step();
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin din = 32'h30 + i; step(); end
        wr_en = 1'b0;
        chk("lit_t1_cnt5", wr_cnt, 5);
        chk("lit_t1_dout0", dout, 32'h30);
        rd_en = 1'b1; rd_rst = 1'b1; step();
        rd_en = 1'b0; rd_rst = 1'b0; step();
        chk("lit_flush_empty", empty, 1);
        chk("lit_flush_cnt", wr_cnt, 0);
        chk("lit_flush_lookup_empty", lookup_empty, 1);
        wr_en = 1'b1; din = 32'h40; step();
        din = 32'h41; step();
        wr_en = 1'b0; step();
        wr_en = 1'b1; din = 32'h42; rd_en = 1'b1; step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("lit_simul_cnt", wr_cnt, 2);
        chk("lit_simul_err", err, 0);
        chk("lit_simul_dout", dout, 32'h41);
        rd_en = 1'b1; step(); rd_en = 1'b0;
        chk("lit_aempty", aempty, 1);
        chk("lit_aempty_dout", dout, 32'h42);

        // Lookup on thread 2.
        wr_thread_num = 4'd2; rd_thread_num = 4'd2; step();
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin din = 32'h20 + i; step(); end
        wr_en = 1'b0;
        chk("lit_lk_dout0", dout, 32'h20);
        chk("lit_lk_notempty0", lookup_empty, 0);
        lookup_en = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            chk("lit_lk_dout", dout, 32'h20 + i);
            chk("lit_lk_notempty", lookup_empty, 0);
        end
        step();
        chk("lit_lk_caught", lookup_empty, 1);
        step();
        lookup_en = 1'b0;
        chk("lit_lk_noop", lookup_empty, 1);
        rd_thread_num = 4'd7; step(); step();
        rd_thread_num = 4'd2; step(); step();
        chk("lit_lk_reload_dout", dout, 32'h20);
        chk("lit_lk_reload_empty", lookup_empty, 0);

        // Wrap on thread 5.
        wr_thread_num = 4'd5; rd_thread_num = 4'd5; step();
        wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin din = 32'h50 + i; step(); end
        wr_en = 1'b0; rd_en = 1'b1;
        repeat (6) step();
        rd_en = 1'b0;
        chk("lit_wrap_empty0", empty, 1);
        wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin din = 32'hA0 + i; step(); end
        wr_en = 1'b0;
        chk("lit_wrap_cnt6", wr_cnt, 6);
        rd_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("lit_wrap_dout", dout, 32'hA0 + i);
            step();
        end
        chk("lit_wrap_empty1", empty, 1);
        step();
        rd_en = 1'b0;
        chk("lit_rd_on_empty_err", err, 0);

        // Overflow on thread 3.
        wr_thread_num = 4'd3; rd_thread_num = 4'd3; step();
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = 32'h10 + i; step();
            chk("lit_ovf_cnt", wr_cnt, i + 1);
            if (i == 6) chk("lit_ovf_notfull", wr_full, 0);
        end
        chk("lit_ovf_full", wr_full, 1);
        chk("lit_ovf_err0", err, 0);
        din = 32'h99; step();
        wr_en = 1'b0;
        chk("lit_ovf_err1", err, 1);
        chk("lit_ovf_cnt_hold", wr_cnt, 8);
`ifdef PROCB_RING_BUF_ERR_INFO_EN
        chk("lit_err_thread", err_thread, 3);
        chk("lit_err_cnt", err_cnt, 1);
`endif
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("lit_ovf_dout", dout, 32'h10 + i);
            step();
        end
        rd_en = 1'b0;
        chk("lit_ovf_empty", empty, 1);

        // Reset in the middle of traffic, then every thread must read back clean.
        wr_thread_num = 4'd9; rd_thread_num = 4'd9; step();
        wr_en = 1'b1; rd_en = 1'b1; lookup_en = 1'b1;
        for (int i = 0; i < 5; i++) begin din = 32'hC0 + i; step(); end
        RST = 1'b1; step(); step();
        RST = 1'b0; wr_en = 1'b0; rd_en = 1'b0; lookup_en = 1'b0;
        repeat (NT + 1) step();
        for (int t = 0; t < NT; t++) begin
            wr_thread_num = 4'(t); rd_thread_num = 4'(t);
            step(); step();
            chk("lit_rst_cnt", wr_cnt, 0);
            chk("lit_rst_empty", empty, 1);
            chk("lit_rst_lookup_empty", lookup_empty, 1);
            chk("lit_rst_err", err, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/procb_ring_buf.md
Name: procb_ring_buf

Overview:
- Next-generation per-thread process_bytes record buffer for the sha512crypt engine. It sits between the host-side procb writer and the SHA block-formation reader.
- Each thread gets a true circular FIFO of N_RECORDS entries with independent read and write pointers, so the writer may refill a thread while it is being consumed.
- Adds full/overflow detection, per-thread flush, and a read-ahead (lookup) pointer with 1st-word fall-through.
- Storage is distributed RAM, N_THREADS*N_RECORDS words.

Parameters:
- N_THREADS, 16, number of threads; power of 2.
- N_THREADS_MSB, `MSB(N_THREADS-1), derived.
- D_WIDTH, `PROCB_D_WIDTH, record width in bits.
- N_RECORDS, 8, records per thread; power of 2, >=2.
- A_WIDTH, `MSB(N_RECORDS-1)+2, pointer/count width; the extra bit distinguishes full from empty.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- wr_thread_num  in  N_THREADS_MSB+1  thread selected for write/count.
- wr_en  in  1  write din to wr_thread_num.
- din  in  D_WIDTH  record data.
- wr_cnt  out  A_WIDTH  occupancy of wr_thread_num (registered).
- wr_full  out  1  wr_cnt == N_RECORDS.
- err  out  1  sticky overflow error.
- rd_thread_num  in  N_THREADS_MSB+1  thread selected for read.
- rd_en  in  1  pop one record.
- rd_rst  in  1  with rd_en: flush the thread after this pop.
- lookup_en  in  1  advance read-ahead pointer.
- empty  out  1  rd thread has 0 records.
- aempty  out  1  rd thread has exactly 1 record.
- lookup_empty  out  1  read-ahead pointer has caught the write pointer.
- dout  out  D_WIDTH  record at read-ahead pointer (FWFT).

Behaviour:
- Reset (async, RST=1):
  - all per-thread wr_ptr/rd_ptr = 0, lookup_ptr = 0;
  - wr_cnt = 0, wr_full = 0, err = 0;
  - empty = 1, aempty = 0, lookup_empty = 1;
  - memory contents are not reset. Pointer RAMs are cleared by a reset sweep: one thread per cycle after RST deasserts, N_THREADS cycles. wr_en/rd_en during the sweep are ignored; the sweep itself does not set err.
- Pointers are A_WIDTH bits and wrap modulo 2^A_WIDTH. Memory index = {thread, ptr[A_WIDTH-2:0]}. Occupancy = wr_ptr - rd_ptr (mod 2^A_WIDTH), range 0..N_RECORDS.
- Write path:
  - wr_cnt is registered from wr_thread_num with 1-cycle latency after a thread change.
  - On a write cycle, wr_cnt updates in the same cycle so back-to-back writes to one thread are counted correctly.
  - wr_en with wr_full=1 (pre-cycle state): write is dropped, pointer unchanged, err <= 1. A simultaneous pop on the same thread does not rescue it.
- Read path:
  - rd thread pointers are registered 1 cycle after rd_thread_num changes; empty/aempty/dout are valid from the 2nd cycle.
  - rd_en with empty=1: ignored, no error.
  - rd_en: rd_ptr += 1. lookup_ptr <= new rd_ptr unless lookup_en is also high, in which case lookup_ptr keeps advancing.
  - rd_en & rd_rst: rd_ptr <= wr_ptr (thread flushed), lookup_ptr <= wr_ptr.
- Lookup path:
  - lookup_ptr reloads to rd_ptr on rd_thread_num change.
  - lookup_en with lookup_empty=0: lookup_ptr += 1. lookup_en with lookup_empty=1: no-op.
  - lookup_empty is registered: (next lookup_ptr == wr_ptr of rd thread).
  - dout = mem[{rd_thread_num, lookup_ptr}], combinational from the registered pointer.
- Simultaneous write and read on the same thread (not full): both take effect.
  - empty/aempty/lookup_empty reflect the write on the next cycle.
  - the new record is visible to the reader no later than 2 cycles after the write.
- Different threads for read and write: fully independent; the pointer RAMs are dual-ported (wr side and rd side).

Optional Feature:
- Macro: PROCB_RING_BUF_ERR_INFO_EN.
- Defined: adds output err_thread [N_THREADS_MSB:0], which captures wr_thread_num of the first rejected write (cleared by RST, frozen while err=1). Also adds output err_cnt [7:0], which saturates at 255 and counts rejected writes.
- Undefined: neither port exists; only sticky err.

Test Plan:
- Reset: pulse RST mid-traffic, wait N_THREADS cycles -> wr_cnt=0, empty=1, lookup_empty=1, err=0 for every thread.
- Thread 3, N_RECORDS=8: write 8 records 0x10..0x17 -> wr_cnt 1..8, wr_full=1 after the 8th. 9th write -> dropped, err=1; pop 8 -> dout 0x10..0x17 in order, then empty=1.
- Wrap: thread 5, write 6, pop 6, write 6 (0xA0..0xA5) -> pointers wrap past 8; pops return 0xA0..0xA5 and occupancy never exceeds 6.
- Lookup: thread 2 holds 4 records; lookup_en x3 -> dout steps through records 1..3, then lookup_empty=0 until a 4th lookup sets it to 1. Switch to thread 7 and back to 2 -> dout returns to record 0.
- Flush/simultaneous: thread 1 holds 5 records; rd_en&rd_rst -> empty=1 within 2 cycles. Same-cycle write to thread 1 plus pop to a non-empty thread 1 -> occupancy unchanged, no err.
